// File: rtl/cycle_ctr_pkg.sv
// Shared constants and types for the manycore timebase block.
// Default counter width and reset-done retiming depth.
package cycle_ctr_pkg;

  localparam int cycle_ctr_width_gp  = 64;
  localparam int reset_done_depth_gp = 3;

  typedef logic [cycle_ctr_width_gp-1:0] cycle_ctr_t;

endpackage

// File: rtl/cycle_ctr_core.sv
// Free-running global cycle counter, synchronous active-high reset.
// Define CYCLE_CTR_SATURATE_EN to hold at all-ones instead of wrapping.
module cycle_ctr_core
  import cycle_ctr_pkg::*;
#(
  parameter int width_p = cycle_ctr_width_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic [width_p-1:0] ctr_r_o
);

  logic [width_p-1:0] ctr_n;

  always_comb begin
    ctr_n = ctr_r_o + width_p'(1);
`ifdef CYCLE_CTR_SATURATE_EN
    if (&ctr_r_o)
      ctr_n = ctr_r_o;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      ctr_r_o <= '0;
    else
      ctr_r_o <= ctr_n;
  end

endmodule

// File: rtl/cycle_ctr_delay_chain.sv
// Timebase: register delay chain plus global cycle counter.
// Counter saturation is selected by CYCLE_CTR_SATURATE_EN.
module cycle_ctr_delay_chain
  import cycle_ctr_pkg::*;
#(
  parameter int width_p      = 1,
  parameter int num_stages_p = reset_done_depth_gp,
  parameter int ctr_width_p  = cycle_ctr_width_gp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data_i,
  output logic [width_p-1:0]     data_o,
  output logic [ctr_width_p-1:0] ctr_r_o
);

  if (width_p < 1) begin : g_bad_width
    $fatal(1, "cycle_ctr_delay_chain: width_p must be >= 1");
  end
  if (num_stages_p < 0) begin : g_bad_stages
    $fatal(1, "cycle_ctr_delay_chain: num_stages_p must be >= 0");
  end
  if (ctr_width_p < 2) begin : g_bad_ctr
    $fatal(1, "cycle_ctr_delay_chain: ctr_width_p must be >= 2");
  end

  if (num_stages_p == 0) begin : g_pass
    assign data_o = data_i;
  end else begin : g_chain
    logic [width_p-1:0] stage_r [num_stages_p];

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int k = 0; k < num_stages_p; k++)
          stage_r[k] <= '0;
      end else begin
        stage_r[0] <= data_i;
        for (int k = 1; k < num_stages_p; k++)
          stage_r[k] <= stage_r[k-1];
      end
    end

    assign data_o = stage_r[num_stages_p-1];
  end

  cycle_ctr_core #(
    .width_p (ctr_width_p)
  ) u_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ctr_r_o (ctr_r_o)
  );

endmodule

// File: tb/tb_cycle_ctr_delay_chain.sv
// Scoreboard bench: three configurations of the timebase block
// driven with random data/reset and checked against a reference model.
module tb_cycle_ctr_delay_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  md = 8'h01;
  logic [7:0]  md_o;
  logic [63:0] mc_o;
  logic [3:0]  pd = 4'h3;
  logic [3:0]  pd_o;
  logic [7:0]  pc_o;
  logic        wd = 1'b0;
  logic        wd_o;
  logic [3:0]  wc_o;

  always #5 clk = ~clk;

  cycle_ctr_delay_chain #(
    .width_p (8), .num_stages_p (3), .ctr_width_p (64)
  ) u_main (
    .clk_i (clk), .reset_i (rst), .data_i (md),
    .data_o (md_o), .ctr_r_o (mc_o)
  );

  cycle_ctr_delay_chain #(
    .width_p (4), .num_stages_p (0), .ctr_width_p (8)
  ) u_pass (
    .clk_i (clk), .reset_i (rst), .data_i (pd),
    .data_o (pd_o), .ctr_r_o (pc_o)
  );

  cycle_ctr_delay_chain #(
    .width_p (1), .num_stages_p (1), .ctr_width_p (4)
  ) u_wrap (
    .clk_i (clk), .reset_i (rst), .data_i (wd),
    .data_o (wd_o), .ctr_r_o (wc_o)
  );

  typedef struct {
    logic [7:0]  md;
    logic [63:0] mc;
    logic [3:0]  pd;
    logic [7:0]  pc;
    logic        wd;
    logic [3:0]  wc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   done   = 0;

  // Counter value after n non-reset edges since the last reset.
  function automatic logic [63:0] ctr_model(longint n, int w);
    longint maxv;
    if (w >= 63) return 64'(n);
    maxv = (longint'(1) << w) - 1;
`ifdef CYCLE_CTR_SATURATE_EN
    return 64'((n > maxv) ? maxv : n);
`else
    return 64'(n % (maxv + 1));
`endif
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one entry per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("main_data", 64'(md_o), 64'(e.md));
        chk("main_ctr",  mc_o,      e.mc);
        chk("pass_data", 64'(pd_o), 64'(e.pd));
        chk("pass_ctr",  64'(pc_o), 64'(e.pc));
        chk("wrap_data", 64'(wd_o), 64'(e.wd));
        chk("wrap_ctr",  64'(wc_o), 64'(e.wc));
      end
    end
  end

  // Driver and reference model.
  initial begin
    logic [7:0] hist_d[$];
    bit         hist_r[$];
    longint     n_edges;
    exp_t       e;
    bit         any_r;

    n_edges = 0;
    for (int i = 0; i < 3; i++) begin
      hist_d.push_back(8'h00);
      hist_r.push_back(1'b1);
    end

    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      rst = (c < 16) || (c == 140) ||
            (c > 160 && $urandom_range(0, 15) == 0);
      if (c < 16)                 md = 8'h01;
      else if (c == 16)           md = 8'hA5;
      else if (c < 20)            md = 8'h00;
      else if (c == 140)          md = 8'h01;
      else if (c > 140 && c < 145) md = 8'h00;
      else                        md = 8'($urandom);
      if (c < 16) pd = c[0] ? 4'hC : 4'h3;
      else        pd = 4'($urandom);
      wd = 1'($urandom);

      // Model of the edge that follows these inputs.
      n_edges = rst ? 0 : n_edges + 1;
      hist_d.push_back(md);
      hist_r.push_back(rst);
      void'(hist_d.pop_front());
      void'(hist_r.pop_front());
      any_r = 1'b0;
      foreach (hist_r[i]) any_r |= hist_r[i];

      e.md = any_r ? 8'h00 : hist_d[0];
      e.mc = ctr_model(n_edges, 64);
      e.pd = pd;
      e.pc = 8'(ctr_model(n_edges, 8));
      e.wd = rst ? 1'b0 : wd;
      e.wc = 4'(ctr_model(n_edges, 4));
      exp_q.push_back(e);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
